abuf_feeder: RTL and testbench
==============================

# abuf_feeder

Streams activation rows from the head-core activation SRAM into the activation buffer's `in_data`/`in_data_vld` port. Each row is issued as a burst of vectors, each `MAC_MULT_NUM*IDATA_WIDTH` bits wide. After a row, the block waits for the buffer's `finish_row` pulse before issuing the next row. It is the transmitter side of the buffer's row protocol, started once per layer phase by the head controller.

## Interface
- `ADDR_WIDTH`, default 10: activation SRAM address width.
- `ROW_CNT_WIDTH`, default 8: width of the row-count configuration.
- `VEC_CNT_WIDTH`, default `$clog2(ABUF_EMBD_REG_DEPTH)+1`: width of the vectors-per-row configuration.
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle start pulse; sampled only in IDLE.
- `cfg_base_addr` input ADDR_WIDTH: address of vector 0 of row 0; latched on accepted start.
- `cfg_row_num` input ROW_CNT_WIDTH: number of rows; latched on accepted start.
- `cfg_vec_per_row` input VEC_CNT_WIDTH: vectors per row; equals the buffer's max_embd_reg_cnt; latched on accepted start.
- `sram_ren` output 1: SRAM read enable; registered.
- `sram_raddr` output ADDR_WIDTH: SRAM read address; registered.
- `sram_rdata` input `MAC_MULT_NUM*IDATA_WIDTH`: read data, valid exactly 1 cycle after `sram_ren`.
- `out_data` output `MAC_MULT_NUM*IDATA_WIDTH`: vector to the buffer's `in_data`; registered.
- `out_data_vld` output 1: to the buffer's `in_data_vld`.
- `finish_row` input 1: one-cycle pulse from the buffer when the current row is fully consumed.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last row's `finish_row`.
- `proto_err` output 1: sticky protocol error; see Configuration.

## Operation
- FSM states are IDLE, ISSUE, WAIT_ROW and DONE.
- IDLE -> ISSUE on `start`, when the latched `cfg_row_num` and `cfg_vec_per_row` are both nonzero.
- IDLE -> DONE on `start` when either of those values is zero. No SRAM reads are issued in that case.
- ISSUE: assert `sram_ren` for `cfg_vec_per_row` consecutive cycles. The address starts at `base + row_idx*cfg_vec_per_row` and increments by 1 per cycle.
- The vector index wraps to 0 after the last vector. ISSUE -> WAIT_ROW on the cycle after the last read of the row.
- WAIT_ROW: hold, with `sram_ren`=0, until `finish_row`=1. Then increment `row_idx`.
  - If `row_idx` was the last row, go to DONE.
  - Otherwise go to ISSUE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Data path: `out_data_vld` is `sram_ren` delayed 2 cycles. `out_data` registers `sram_rdata` on the cycle after `sram_ren`.
- `out_data` is 0 whenever `out_data_vld`=0.
- There is no backpressure: the buffer accepts every valid vector.
- Address arithmetic is modulo 2^ADDR_WIDTH; a wrap past the top address is legal and silent.
- `start` outside IDLE is ignored, and the configuration is not re-latched.
- `finish_row` outside WAIT_ROW is ignored for control purposes; see Configuration for `proto_err`.
- Reset, including mid-row: every register is cleared and the FSM returns to IDLE. In-flight SRAM data is discarded; `out_data_vld` is 0 from reset onward.

## Timing
- Reset values: `sram_ren`=0, `sram_raddr`=0, `out_data`=0, `out_data_vld`=0, `busy`=0, `done`=0, `proto_err`=0.
- Start latency: `start` in cycle 0 gives `sram_ren`=1 in cycles 1..N (N = `cfg_vec_per_row`), `out_data_vld`=1 in cycles 3..N+2, and `busy`=1 from cycle 1.
- Row turnaround: `finish_row` in cycle F gives the next row's first `sram_ren` in cycle F+1 and its first `out_data_vld` in cycle F+3.
- Completion: last `finish_row` in cycle F gives `done`=1 in cycle F+1 and `busy`=0 in cycle F+2.
- Zero-config start in cycle 0 gives `done`=1 in cycle 1.

## Configuration
- `ABUF_FEEDER_PROTO_CHECK_EN` defined:
  - `proto_err` sets when `finish_row`=1 in any state other than WAIT_ROW.
  - `proto_err` also sets when a start is accepted with `cfg_vec_per_row`=0 or `cfg_vec_per_row` > `ABUF_EMBD_REG_DEPTH`.
  - Once set, it clears only on reset or on the next accepted `start`.
- Undefined: `proto_err` is tied to 0, and no checking logic is present.
- Control behaviour is identical in both builds.

## Test plan
- Base 0x010, 2 rows, 4 vectors per row; buffer model pulses `finish_row` 5 cycles after the last valid -> addresses 0x010–0x013 then 0x014–0x017; `out_data` equals the SRAM contents in order; `done` 1 cycle after the second `finish_row`.
- 1 row, 1 vector: `start` in cycle 0 -> `sram_ren` in cycle 1 only, `out_data_vld` in cycle 3 only, `busy` high from cycle 1 until `done`.
- Base 0x3FE, 1 row, 4 vectors, ADDR_WIDTH=10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- `cfg_row_num`=0 -> `done` in cycle 1, no `sram_ren`; a second `start` pulsed while busy on a 3x8 job is ignored and exactly 24 vectors are sent.
- `rst_n` asserted in the middle of row 1 of a 3x8 job -> all outputs 0 immediately; a fresh `start` reissues from base with correct ordering.
- With `ABUF_FEEDER_PROTO_CHECK_EN`: `finish_row` during ISSUE -> `proto_err`=1 while the row still completes; the next accepted `start` clears it. Without the macro, `proto_err` stays 0.

Source files
------------

// File: rtl/abuf_feeder_if.sv
// abuf_feeder_if: SRAM read port plus activation-buffer row port between the feeder and its neighbours.
interface abuf_feeder_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  sram_ren;
   logic [ADDR_WIDTH-1:0] sram_raddr;
   logic [DATA_WIDTH-1:0] sram_rdata;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_data_vld;
   logic                  finish_row;
   modport master (
      output sram_ren, sram_raddr, out_data, out_data_vld,
      input  sram_rdata, finish_row
   );
   modport slave (
      input  sram_ren, sram_raddr, out_data, out_data_vld,
      output sram_rdata, finish_row
   );
endinterface

// File: rtl/abuf_feeder.sv
// abuf_feeder: streams activation rows from SRAM into the activation buffer, one row per finish_row handshake.
// Define ABUF_FEEDER_PROTO_CHECK_EN to build the sticky proto_err checker; otherwise proto_err is tied low.
module abuf_feeder #(
   parameter int ADDR_WIDTH          = 10,
   parameter int ROW_CNT_WIDTH       = 8,
   parameter int MAC_MULT_NUM        = 4,
   parameter int IDATA_WIDTH         = 8,
   parameter int ABUF_EMBD_REG_DEPTH = 16,
   parameter int VEC_CNT_WIDTH       = $clog2(ABUF_EMBD_REG_DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDR_WIDTH-1:0]    cfg_base_addr,
   input  logic [ROW_CNT_WIDTH-1:0] cfg_row_num,
   input  logic [VEC_CNT_WIDTH-1:0] cfg_vec_per_row,
   abuf_feeder_if.master            bus,
   output logic                     busy,
   output logic                     done,
   output logic                     proto_err
);
   localparam int DW = MAC_MULT_NUM * IDATA_WIDTH;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ROW, DONE} state_t;
   state_t                   state_q, state_d;
   logic [VEC_CNT_WIDTH-1:0] vpr_q, vpr_d, vec_q, vec_d;
   logic [ROW_CNT_WIDTH-1:0] rows_q, rows_d, row_q, row_d;
   logic [ADDR_WIDTH-1:0]    row_addr_q, row_addr_d, raddr_q, raddr_d, next_row_addr;
   logic                     ren_q, ren_d, ren_p_q, ren_p_d, vld_q, vld_d;
   logic [DW-1:0]            data_q, data_d;
   logic                     vec_last, row_last;
   // row_addr_q tracks base + row_idx*vec_per_row incrementally, so no multiplier is needed
   always_comb begin
      vec_last      = vec_q == vpr_q - 1'b1;
      row_last      = row_q == rows_q - 1'b1;
      next_row_addr = row_addr_q + ADDR_WIDTH'(vpr_q);
      state_d       = state_q;
      vpr_d         = vpr_q;
      rows_d        = rows_q;
      vec_d         = vec_q;
      row_d         = row_q;
      row_addr_d    = row_addr_q;
      raddr_d       = raddr_q;
      ren_d         = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            vpr_d      = cfg_vec_per_row;
            rows_d     = cfg_row_num;
            row_addr_d = cfg_base_addr;
            raddr_d    = cfg_base_addr;
            row_d      = '0;
            vec_d      = '0;
            ren_d      = cfg_row_num != '0 && cfg_vec_per_row != '0;
            state_d    = ren_d ? ISSUE : DONE;
         end
         ISSUE: begin
            vec_d   = vec_last ? '0 : vec_q + 1'b1;
            ren_d   = !vec_last;
            raddr_d = vec_last ? raddr_q : raddr_q + 1'b1;
            state_d = vec_last ? WAIT_ROW : ISSUE;
         end
         WAIT_ROW: if (bus.finish_row) begin
            row_d      = row_q + 1'b1;
            ren_d      = !row_last;
            row_addr_d = next_row_addr;
            raddr_d    = next_row_addr;
            state_d    = row_last ? DONE : ISSUE;
         end
         default: state_d = IDLE;
      endcase
      ren_p_d = ren_q;
      vld_d   = ren_p_q;
      data_d  = ren_p_q ? bus.sram_rdata : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         vpr_q      <= '0;
         rows_q     <= '0;
         vec_q      <= '0;
         row_q      <= '0;
         row_addr_q <= '0;
         raddr_q    <= '0;
         ren_q      <= 1'b0;
         ren_p_q    <= 1'b0;
         vld_q      <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         vpr_q      <= vpr_d;
         rows_q     <= rows_d;
         vec_q      <= vec_d;
         row_q      <= row_d;
         row_addr_q <= row_addr_d;
         raddr_q    <= raddr_d;
         ren_q      <= ren_d;
         ren_p_q    <= ren_p_d;
         vld_q      <= vld_d;
         data_q     <= data_d;
      end
   end
   assign bus.sram_ren     = ren_q;
   assign bus.sram_raddr   = raddr_q;
   assign bus.out_data     = data_q;
   assign bus.out_data_vld = vld_q;
   assign busy             = state_q != IDLE;
   assign done             = state_q == DONE;
`ifdef ABUF_FEEDER_PROTO_CHECK_EN
   logic proto_err_q, proto_err_d, stray_fin, bad_cfg, start_acc;
   // an accepted start clears old errors but still reports a bad config or stray pulse in that cycle
   always_comb begin
      start_acc   = state_q == IDLE && start;
      stray_fin   = bus.finish_row && state_q != WAIT_ROW;
      bad_cfg     = cfg_vec_per_row == '0 || 32'(cfg_vec_per_row) > 32'(ABUF_EMBD_REG_DEPTH);
      proto_err_d = start_acc ? (bad_cfg || stray_fin) : (proto_err_q || stray_fin);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) proto_err_q <= 1'b0;
      else        proto_err_q <= proto_err_d;
   end
   assign proto_err = proto_err_q;
`else
   assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_abuf_feeder.sv
// tb_abuf_feeder: randomized and directed jobs against a queue-based address/data scoreboard and a cycle-level buffer model.
module tb_abuf_feeder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [9:0] cfg_base = '0;
   logic [7:0] cfg_rows = '0;
   logic [4:0] cfg_vpr = '0;
   logic       busy, done, proto_err;
   int         fin_delay = 3;
   bit         stray_en = 1'b0;
   int         checks = 0, errors = 0, cyc = 0;
   logic [31:0] mem [1024];

   abuf_feeder_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

   abuf_feeder dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .cfg_base_addr   (cfg_base),
      .cfg_row_num     (cfg_rows),
      .cfg_vec_per_row (cfg_vpr),
      .bus             (bus.master),
      .busy            (busy),
      .done            (done),
      .proto_err       (proto_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (bus.sram_ren) bus.sram_rdata <= mem[bus.sram_raddr];

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   logic [9:0]  aq[$];
   logic [31:0] dq[$];
   logic [9:0]  ea;
   logic [31:0] ed;
   int  trig, done_due = -1, rows_left, vpr, rd_in_row, vld_in_row, fin_cnt, age;
   bit  trig_ok, mbusy, mwait, exp_perr, pren, pvld, stray_done;
   bit  fire_stray, set_wait, stray_now, bad;

   always @(negedge clk) begin
      fire_stray = 1'b0;
      set_wait   = 1'b0;
      stray_now  = 1'b0;
      if (!rst_n) begin
         chk(!bus.sram_ren && bus.sram_raddr == 0 && bus.out_data == 0 && !bus.out_data_vld && !busy && !done && !proto_err,
             "reset_outputs", {bus.out_data, bus.sram_raddr, busy, done, proto_err, bus.sram_ren, bus.out_data_vld}, 0);
         aq.delete(); dq.delete();
         mbusy = 0; mwait = 0; exp_perr = 0; trig_ok = 0; done_due = -1;
         fin_cnt = 0; rd_in_row = 0; vld_in_row = 0; pren = 0; pvld = 0; age = 0;
         bus.finish_row = 1'b0;
      end else begin
         chk(busy == mbusy, "busy", busy, mbusy);
         chk(done == (cyc == done_due), "done", done, cyc == done_due);
         chk(proto_err == exp_perr, "proto_err", proto_err, exp_perr);
         if (bus.sram_ren) begin
            if (!pren && trig_ok) chk(cyc == trig + 1, "ren_latency", cyc - trig, 1);
            if (aq.size() == 0) chk(0, "extra_read", bus.sram_raddr, 0);
            else begin
               ea = aq.pop_front();
               chk(bus.sram_raddr == ea, "raddr", bus.sram_raddr, ea);
            end
            fire_stray = stray_en && !stray_done && rd_in_row == 1;
            rd_in_row++;
            if (rd_in_row == vpr) begin rd_in_row = 0; set_wait = 1; end
         end
         if (bus.out_data_vld) begin
            if (!pvld && trig_ok) chk(cyc == trig + 3, "vld_latency", cyc - trig, 3);
            if (dq.size() == 0) chk(0, "extra_vector", bus.out_data, 0);
            else begin
               ed = dq.pop_front();
               chk(bus.out_data == ed, "out_data", bus.out_data, ed);
            end
            vld_in_row++;
            if (vld_in_row == vpr) begin vld_in_row = 0; fin_cnt = fin_delay + 1; end
         end else chk(bus.out_data == 0, "data_idle_zero", bus.out_data, 0);
         pren = bus.sram_ren;
         pvld = bus.out_data_vld;
         bus.finish_row = 1'b0;
         if (fin_cnt > 0) begin fin_cnt--; if (fin_cnt == 0) bus.finish_row = 1'b1; end
         if (fire_stray) begin bus.finish_row = 1'b1; stray_done = 1; end
         if (bus.finish_row) begin
            if (mwait) begin
               mwait = 0; rows_left--; trig = cyc;
               if (rows_left == 0) done_due = cyc + 1;
            end else stray_now = 1;
         end
         if (set_wait) mwait = 1;
         if (cyc == done_due) chk(aq.size() == 0 && dq.size() == 0, "all_sent", aq.size() + dq.size(), 0);
         if (start && !mbusy) begin
            trig = cyc; trig_ok = 1; vpr = int'(cfg_vpr); rd_in_row = 0; vld_in_row = 0;
            stray_done = 0; age = 0; mbusy = 1;
            bad = cfg_vpr == 0 || cfg_vpr > 16;
            if (cfg_rows == 0 || cfg_vpr == 0) done_due = cyc + 1;
            else begin
               rows_left = int'(cfg_rows);
               for (int i = 0; i < int'(cfg_rows) * int'(cfg_vpr); i++) begin
                  ea = cfg_base + 10'(i);
                  aq.push_back(ea);
                  dq.push_back(mem[ea]);
               end
            end
`ifdef ABUF_FEEDER_PROTO_CHECK_EN
            exp_perr = bad | stray_now;
`endif
         end else begin
`ifdef ABUF_FEEDER_PROTO_CHECK_EN
            exp_perr = exp_perr | stray_now;
`endif
            if (cyc == done_due) mbusy = 0;
         end
         if (mbusy) age++;
         if (age > 3000) begin
            chk(0, "timeout", age, 0);
            mbusy = 0; mwait = 0; age = 0; done_due = -1; aq.delete(); dq.delete();
         end
      end
   end

   task automatic kick(input logic [9:0] b, input logic [7:0] r, input logic [4:0] v, input int d);
      @(posedge clk); #1;
      cfg_base = b; cfg_rows = r; cfg_vpr = v; fin_delay = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 4000) begin @(posedge clk); #1; n++; end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      kick(10'h010, 8'd2, 5'd4, 5); wait_idle();
      kick(10'h000, 8'd1, 5'd1, 3); wait_idle();
      kick(10'h3FE, 8'd1, 5'd4, 2); wait_idle();
      kick(10'h100, 8'd0, 5'd4, 2); wait_idle();
      kick(10'h040, 8'd3, 5'd8, 3);
      repeat (10) @(posedge clk);
      kick(10'h200, 8'd1, 5'd2, 3); wait_idle();
      kick(10'h080, 8'd3, 5'd8, 3);
      repeat (14) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      kick(10'h080, 8'd3, 5'd8, 3); wait_idle();
      stray_en = 1'b1;
      kick(10'h020, 8'd2, 5'd4, 4); wait_idle();
      stray_en = 1'b0;
      kick(10'h000, 8'd1, 5'd0, 2); wait_idle();
      kick(10'h300, 8'd1, 5'd17, 2); wait_idle();
      kick(10'h030, 8'd1, 5'd3, 2); wait_idle();
      for (int k = 0; k < 8; k++) begin
         kick(10'($urandom), 8'($urandom_range(1, 4)), 5'($urandom_range(1, 16)), int'($urandom_range(1, 6)));
         wait_idle();
      end
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
